ftdi_tx_scheduler: RTL and testbench

Sequences writes into the FTDI 245-style synchronous FIFO TX port and shares that port between two upstream byte sources.
- Each source raises a packet-ready flag once a full packet is buffered.
- The scheduler grants one source with round-robin, emits a 1-byte channel header, then streams exactly PKT_BYTES payload bytes, honouring txe_n backpressure.
- Optionally pulses siwu_n after each packet so the FTDI flushes to USB.
- Sits between the per-channel capture FIFOs and the FTDI pins, in the FTDI clock domain.

---
 rtl/ftdi_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_ftdi_tx_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_tx_scheduler.sv
// ftdi_tx_scheduler
//   Shares the FTDI 245-style synchronous FIFO TX port between two byte
//   sources. A ready source is granted round-robin. The scheduler then
//   sends a one-byte channel header followed by PKT_BYTES payload bytes,
//   and holds off whenever txe_n is high. When SEND_IMMEDIATE is set, it
//   pulses siwu_n after each completed packet so the FTDI flushes to USB.
//
// Ports
//   clk          FTDI 60 MHz clock
//   rst          synchronous, active-high reset
//   src_pkt_rdy  [1:0]  per-source: a full packet is buffered
//   src_valid    [1:0]  per-source: src_data byte valid (FWFT)
//   src_data     [15:0] source0 in [7:0], source1 in [15:8]
//   src_pop      [1:0]  one-hot pop; byte consumed at this edge
//   txe_n               FTDI TX FIFO not-ready (active low)
//   wr_n                FTDI write strobe (active low)
//   ftdi_data    [7:0]  FTDI data bus
//   siwu_n              FTDI send-immediate (active low)
//   grant        [1:0]  one-hot active source, 0 when idle
//   busy                any state other than IDLE
//   err_stall           sticky source-underflow abort flag
//   pkt_cnt      [15:0] completed packet count (wraps)
module ftdi_tx_scheduler #(
    parameter int unsigned PKT_BYTES      = 4096,
    parameter bit          SEND_IMMEDIATE = 1'b1,
    parameter int unsigned STALL_MAX      = 1023,
    parameter logic [7:0]  HDR_BASE       = 8'hA0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  src_pkt_rdy,
    input  logic [1:0]  src_valid,
    input  logic [15:0] src_data,
    output logic [1:0]  src_pop,
    input  logic        txe_n,
    output logic        wr_n,
    output logic [7:0]  ftdi_data,
    output logic        siwu_n,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        err_stall,
    output logic [15:0] pkt_cnt
);

    // The stall counter only has to hold 0..STALL_MAX-1. The abort fires
    // on the underflow cycle that would take it to STALL_MAX.
    localparam int unsigned STALL_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;

    typedef enum logic [2:0] {IDLE, HDR, XFER, FLUSH, DONE} state_t;

    state_t               state_q;
    logic [1:0]           grant_q;
    logic                 gidx_q;     // index of the granted source
    logic                 last_q;     // last-served source
    logic [15:0]          cnt_q;      // payload bytes still to send
    logic [STALL_W-1:0]   stall_q;
    logic                 err_q;
    logic [15:0]          pkt_q;

    logic                 pick;
    logic                 cur_valid;
    logic [7:0]           cur_byte;
    logic                 xfer;

    always_comb begin
        // When both sources request, the one not served last wins.
        pick      = (src_pkt_rdy == 2'b11) ? ~last_q : src_pkt_rdy[1];
        cur_valid = src_valid[gidx_q];
        cur_byte  = gidx_q ? src_data[15:8] : src_data[7:0];
        xfer      = 1'b0;
        ftdi_data = '0;
        case (state_q)
            HDR: begin
                xfer      = ~txe_n;
                ftdi_data = HDR_BASE | {7'd0, gidx_q};
            end
            XFER: begin
                xfer      = ~txe_n & cur_valid;
                ftdi_data = cur_byte;
            end
            default: ;
        endcase
    end

    assign wr_n      = ~xfer;
    assign src_pop   = (state_q == XFER && xfer) ? (gidx_q ? 2'b10 : 2'b01) : '0;
    assign siwu_n    = (state_q != FLUSH);
    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;
    assign err_stall = err_q;
    assign pkt_cnt   = pkt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|src_pkt_rdy) begin
                        gidx_q  <= pick;
                        grant_q <= pick ? 2'b10 : 2'b01;
                        cnt_q   <= 16'(PKT_BYTES);
                        stall_q <= '0;
                        state_q <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) state_q <= XFER;
                end
                XFER: begin
                    if (xfer) begin
                        cnt_q   <= cnt_q - 16'd1;
                        stall_q <= '0;
                        if (cnt_q == 16'd1) begin
                            pkt_q  <= pkt_q + 16'd1;
                            last_q <= gidx_q;
                            if (SEND_IMMEDIATE) begin
                                state_q <= FLUSH;
                            end else begin
                                grant_q <= '0;
                                state_q <= DONE;
                            end
                        end
                    end else if (!txe_n) begin
                        // Source underflow. Cycles with txe_n high leave the counter alone.
                        if (stall_q == STALL_W'(STALL_MAX - 1)) begin
                            err_q   <= 1'b1;
                            last_q  <= gidx_q;
                            grant_q <= '0;
                            state_q <= DONE;
                        end else begin
                            stall_q <= stall_q + STALL_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    grant_q <= '0;
                    state_q <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ftdi_tx_scheduler.sv
module tb_ftdi_tx_scheduler;

    localparam int         PKT  = 8;
    localparam int         SMAX = 4;
    localparam logic [7:0] HDR  = 8'hA0;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  src_pkt_rdy, src_valid;
    logic [15:0] src_data;
    logic        txe_n;

    logic [1:0]  a_pop, a_grant, b_pop, b_grant, o_pop, o_grant;
    logic        a_wr_n, a_siwu_n, a_busy, a_err, b_wr_n, b_siwu_n, b_busy, b_err;
    logic        o_wr_n, o_siwu_n, o_busy, o_err;
    logic [7:0]  a_data, b_data, o_data;
    logic [15:0] a_cnt, b_cnt, o_cnt;
    bit          sel_b;

    always #5 clk = ~clk;

    ftdi_tx_scheduler #(.PKT_BYTES(PKT), .SEND_IMMEDIATE(1'b1), .STALL_MAX(SMAX), .HDR_BASE(HDR)) dut_a (
        .clk(clk), .rst(rst), .src_pkt_rdy(src_pkt_rdy), .src_valid(src_valid), .src_data(src_data),
        .src_pop(a_pop), .txe_n(txe_n), .wr_n(a_wr_n), .ftdi_data(a_data), .siwu_n(a_siwu_n),
        .grant(a_grant), .busy(a_busy), .err_stall(a_err), .pkt_cnt(a_cnt));

    ftdi_tx_scheduler #(.PKT_BYTES(PKT), .SEND_IMMEDIATE(1'b0), .STALL_MAX(SMAX), .HDR_BASE(HDR)) dut_b (
        .clk(clk), .rst(rst), .src_pkt_rdy(src_pkt_rdy), .src_valid(src_valid), .src_data(src_data),
        .src_pop(b_pop), .txe_n(txe_n), .wr_n(b_wr_n), .ftdi_data(b_data), .siwu_n(b_siwu_n),
        .grant(b_grant), .busy(b_busy), .err_stall(b_err), .pkt_cnt(b_cnt));

    assign o_pop    = sel_b ? b_pop    : a_pop;
    assign o_grant  = sel_b ? b_grant  : a_grant;
    assign o_wr_n   = sel_b ? b_wr_n   : a_wr_n;
    assign o_siwu_n = sel_b ? b_siwu_n : a_siwu_n;
    assign o_busy   = sel_b ? b_busy   : a_busy;
    assign o_err    = sel_b ? b_err    : a_err;
    assign o_data   = sel_b ? b_data   : a_data;
    assign o_cnt    = sel_b ? b_cnt    : a_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: packet-level view of the port
    int         cyc = 0, done_cyc, flush_cyc, pos, stall, ends;
    bit         in_pkt, ch, last, err_m, idle_prev;
    logic [15:0] pkt_m;
    logic [1:0] prev_rdy;
    logic [7:0] q0[$], q1[$];
    int         lg_cyc[$], siwu_lo[$];
    logic [7:0] lg_dat[$];
    // Stimulus controls
    int         bp_at, bp_left, bp_high, starve_at;
    bit         bp_forced, txe_rand, val_rand, force_txe;
    bit [1:0]   starve, rdy_en;

    function automatic logic [7:0] front(input bit c);
        if (c) return (q1.size() > 0) ? q1[0] : 8'h00;
        return (q0.size() > 0) ? q0[0] : 8'h00;
    endfunction

    task automatic do_reset(input bit use_b);
        sel_b = use_b; rst = 1'b1; txe_n = 1'b1;
        src_valid = '0; src_pkt_rdy = '0; src_data = '0;
        q0.delete(); q1.delete(); lg_cyc.delete(); lg_dat.delete(); siwu_lo.delete();
        bp_at = -1; bp_left = 0; bp_high = 0; starve_at = -1; starve = '0; rdy_en = '0;
        txe_rand = 0; val_rand = 0; force_txe = 0; ends = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        in_pkt = 0; pkt_m = '0; err_m = 0; last = 1; done_cyc = cyc - 1;
        flush_cyc = -10; idle_prev = 0; prev_rdy = '0; stall = 0;
    endtask

    // One clock: drive at posedge+1, sample and advance the model at negedge.
    task automatic step();
        logic       exp_wr, exp_busy, was_idle;
        logic [1:0] oh, exp_pop;
        logic [7:0] exp_d;
        if (bp_left > 0) begin
            txe_n = 1'b1; bp_left--; bp_forced = 1'b1;
        end else begin
            bp_forced = 1'b0;
            txe_n = txe_rand ? ($urandom_range(0, 3) == 0) : force_txe;
        end
        src_valid[0] = (q0.size() > 0) && !starve[0] && (!val_rand || $urandom_range(0, 4) != 0);
        src_valid[1] = (q1.size() > 0) && !starve[1] && (!val_rand || $urandom_range(0, 4) != 0);
        src_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'($urandom);
        src_data[15:8] = (q1.size() > 0) ? q1[0] : 8'($urandom);
        src_pkt_rdy[0] = rdy_en[0] && (q0.size() >= PKT);
        src_pkt_rdy[1] = rdy_en[1] && (q1.size() >= PKT);
        @(negedge clk);

        checks++;
        if (o_cnt !== pkt_m) begin errors++; $display("FAIL pkt_cnt cyc %0d: got %0d want %0d", cyc, o_cnt, pkt_m); end
        checks++;
        if (o_err !== err_m) begin errors++; $display("FAIL err_stall cyc %0d: got %b want %b", cyc, o_err, err_m); end

        was_idle = 1'b0;
        exp_busy = 1'b0;
        if (!in_pkt) begin
            if (cyc <= done_cyc) exp_busy = 1'b1;
            else if (idle_prev && prev_rdy != 2'b00) begin
                ch = (prev_rdy == 2'b11) ? !last : prev_rdy[1];
                in_pkt = 1; pos = 0; stall = 0;
            end else was_idle = 1'b1;
        end

        if (in_pkt) begin
            oh = ch ? 2'b10 : 2'b01;
            checks++;
            if (o_grant !== oh || o_busy !== 1'b1 || o_siwu_n !== 1'b1) begin
                errors++;
                $display("FAIL active cyc %0d: got grant=%b busy=%b siwu_n=%b want grant=%b busy=1 siwu_n=1",
                         cyc, o_grant, o_busy, o_siwu_n, oh);
            end
            exp_wr = (pos == 0) ? txe_n : !(!txe_n && src_valid[ch]);
            checks++;
            if (o_wr_n !== exp_wr) begin errors++; $display("FAIL wr_n cyc %0d pos %0d: got %b want %b", cyc, pos, o_wr_n, exp_wr); end
            if (!exp_wr) begin
                exp_d   = (pos == 0) ? (HDR | {7'd0, ch}) : front(ch);
                exp_pop = (pos == 0) ? 2'b00 : oh;
                checks++;
                if (o_data !== exp_d || o_pop !== exp_pop) begin
                    errors++;
                    $display("FAIL byte cyc %0d pos %0d: got data=%h pop=%b want data=%h pop=%b",
                             cyc, pos, o_data, o_pop, exp_d, exp_pop);
                end
                lg_cyc.push_back(cyc); lg_dat.push_back(o_data);
                if (pos > 0) begin
                    if (ch) void'(q1.pop_front()); else void'(q0.pop_front());
                end
                pos++; stall = 0;
                if (pos == bp_at) begin bp_left = 5; bp_at = -1; end
                if (pos == starve_at && !ch) starve[0] = 1'b1;
                if (pos == PKT + 1) begin
                    pkt_m = pkt_m + 16'd1; last = ch; in_pkt = 0; ends++;
                    if (!sel_b) begin flush_cyc = cyc + 1; done_cyc = cyc + 2; end
                    else begin flush_cyc = -10; done_cyc = cyc + 1; end
                end
            end else begin
                checks++;
                if (o_pop !== 2'b00) begin errors++; $display("FAIL idle pop cyc %0d: got %b want 00", cyc, o_pop); end
                if (pos > 0 && !txe_n) begin
                    stall++;
                    if (stall == SMAX) begin
                        err_m = 1; last = ch; in_pkt = 0; ends++; done_cyc = cyc + 1; flush_cyc = -10;
                    end
                end
            end
        end else begin
            checks++;
            if (o_busy !== exp_busy || o_wr_n !== 1'b1 || o_pop !== 2'b00 || o_data !== 8'h00) begin
                errors++;
                $display("FAIL gap cyc %0d: got busy=%b wr_n=%b pop=%b data=%h want busy=%b wr_n=1 pop=00 data=00",
                         cyc, o_busy, o_wr_n, o_pop, o_data, exp_busy);
            end
            if (cyc != flush_cyc) begin
                checks++;
                if (o_grant !== 2'b00) begin errors++; $display("FAIL gap grant cyc %0d: got %b want 00", cyc, o_grant); end
            end
            checks++;
            if (o_siwu_n !== (cyc != flush_cyc)) begin
                errors++; $display("FAIL siwu_n cyc %0d: got %b want %b", cyc, o_siwu_n, cyc != flush_cyc);
            end
        end

        if (o_siwu_n === 1'b0) siwu_lo.push_back(cyc);
        if (bp_forced && o_wr_n === 1'b1) bp_high++;
        idle_prev = was_idle;
        prev_rdy  = src_pkt_rdy;
        if (rst) begin
            in_pkt = 0; pkt_m = '0; err_m = 0; last = 1; done_cyc = cyc;
            flush_cyc = -10; idle_prev = 0; stall = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset(0);
        checks++;
        if ({o_wr_n, o_siwu_n, o_pop, o_data, o_grant, o_busy, o_err, o_cnt} !== {1'b1, 1'b1, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset: got wr_n=%b siwu_n=%b pop=%b data=%h grant=%b busy=%b err=%b cnt=%0d want 1 1 00 00 00 0 0 0",
                     o_wr_n, o_siwu_n, o_pop, o_data, o_grant, o_busy, o_err, o_cnt);
        end
    endtask

    task automatic test_single_packet();
        int g = 0;
        do_reset(0);
        for (int i = 0; i < 8; i++) q0.push_back(8'(i));
        rdy_en = 2'b01;
        while (pkt_m < 1 && g < 40) begin step(); g++; end
        repeat (4) step();
        checks++;
        if (lg_dat.size() != 9) begin errors++; $display("FAIL single count: got %0d want 9", lg_dat.size()); end
        else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (lg_dat[i] !== ((i == 0) ? 8'hA0 : 8'(i - 1)) || lg_cyc[i] != lg_cyc[0] + i) begin
                    errors++;
                    $display("FAIL single byte %0d: got %h at +%0d want %h at +%0d", i, lg_dat[i], lg_cyc[i] - lg_cyc[0],
                             (i == 0) ? 8'hA0 : 8'(i - 1), i);
                end
            end
            checks++;
            if (siwu_lo.size() != 1 || siwu_lo[0] != lg_cyc[8] + 1) begin
                errors++; $display("FAIL single siwu: got %0d pulses want 1 at cyc %0d", siwu_lo.size(), lg_cyc[8] + 1);
            end
        end
        checks++;
        if (o_grant !== 2'b00 || o_cnt !== 16'd1) begin
            errors++; $display("FAIL single end: got grant=%b cnt=%0d want 00 1", o_grant, o_cnt);
        end
    endtask

    task automatic test_round_robin();
        int g = 0;
        do_reset(0);
        for (int i = 0; i < 2 * PKT; i++) begin q0.push_back(8'($urandom)); q1.push_back(8'($urandom)); end
        rdy_en = 2'b11;
        while (pkt_m < 4 && g < 100) begin step(); g++; end
        checks++;
        if (lg_dat.size() != 4 * (PKT + 1)) begin errors++; $display("FAIL rr count: got %0d want %0d", lg_dat.size(), 4 * (PKT + 1)); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (lg_dat[k * (PKT + 1)] !== ((k % 2 == 1) ? 8'hA1 : 8'hA0)) begin
                    errors++; $display("FAIL rr header %0d: got %h want %h", k, lg_dat[k * (PKT + 1)], (k % 2 == 1) ? 8'hA1 : 8'hA0);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int g = 0;
        logic [7:0] exp_q[$];
        do_reset(0);
        for (int i = 0; i < PKT; i++) q0.push_back(8'($urandom));
        exp_q = q0;
        rdy_en = 2'b01; bp_at = 4;
        while (pkt_m < 1 && g < 60) begin step(); g++; end
        checks++;
        if (bp_high != 5) begin errors++; $display("FAIL bp wr_n high cycles: got %0d want 5", bp_high); end
        checks++;
        if (lg_dat.size() != PKT + 1) begin errors++; $display("FAIL bp count: got %0d want %0d", lg_dat.size(), PKT + 1); end
        else begin
            checks++;
            if (lg_cyc[4] - lg_cyc[3] != 6) begin errors++; $display("FAIL bp resume gap: got %0d want 6", lg_cyc[4] - lg_cyc[3]); end
            for (int i = 0; i < PKT; i++) begin
                checks++;
                if (lg_dat[i + 1] !== exp_q[i]) begin errors++; $display("FAIL bp payload %0d: got %h want %h", i, lg_dat[i + 1], exp_q[i]); end
            end
        end
    endtask

    task automatic test_underflow();
        int g = 0;
        do_reset(0);
        for (int i = 0; i < 2 * PKT; i++) q0.push_back(8'($urandom));
        for (int i = 0; i < PKT; i++) q1.push_back(8'($urandom));
        rdy_en = 2'b11; starve_at = 3;
        while (!err_m && g < 60) begin step(); g++; end
        checks++;
        if (o_err !== 1'b1 || o_cnt !== 16'd0) begin
            errors++; $display("FAIL uf abort: got err=%b cnt=%0d want 1 0", o_err, o_cnt);
        end
        g = 0;
        while (pkt_m < 1 && g < 60) begin step(); g++; end
        checks++;
        if (lg_dat.size() != 3 + PKT + 1 || lg_dat[3] !== 8'hA1) begin
            errors++; $display("FAIL uf next grant: got %0d bytes, header %h want %0d bytes, header a1",
                               lg_dat.size(), (lg_dat.size() > 3) ? lg_dat[3] : 8'h00, 3 + PKT + 1);
        end
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL uf sticky: got %b want 1", o_err); end
    endtask

    task automatic test_reset_mid();
        int g = 0;
        do_reset(0);
        for (int i = 0; i < 3 * PKT; i++) q0.push_back(8'($urandom));
        rdy_en = 2'b01;
        while (pkt_m < 1 && g < 40) begin step(); g++; end
        g = 0;
        while (!(in_pkt && pos == 4) && g < 40) begin step(); g++; end
        checks++;
        if (!(in_pkt && pos == 4)) begin errors++; $display("FAIL mid reach: got pos=%0d want 4", pos); end
        rst = 1'b1; force_txe = 1'b1;
        step();
        rst = 1'b0; force_txe = 1'b0;
        checks++;
        if (o_wr_n !== 1'b1 || o_grant !== 2'b00 || o_cnt !== 16'd0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL mid reset: got wr_n=%b grant=%b cnt=%0d busy=%b want 1 00 0 0", o_wr_n, o_grant, o_cnt, o_busy);
        end
        lg_dat.delete(); lg_cyc.delete();
        g = 0;
        while (pkt_m < 1 && g < 60) begin step(); g++; end
        checks++;
        if (lg_dat.size() == 0 || lg_dat[0] !== 8'hA0 || o_cnt !== 16'd1) begin
            errors++; $display("FAIL mid restart: got header %h cnt=%0d want a0 1", (lg_dat.size() > 0) ? lg_dat[0] : 8'h00, o_cnt);
        end
    endtask

    task automatic test_no_flush();
        int g = 0;
        do_reset(1);
        for (int i = 0; i < PKT; i++) begin q0.push_back(8'($urandom)); q1.push_back(8'($urandom)); end
        rdy_en = 2'b11;
        while (pkt_m < 2 && g < 80) begin step(); g++; end
        repeat (3) step();
        checks++;
        if (siwu_lo.size() != 0 || o_cnt !== 16'd2) begin
            errors++; $display("FAIL no_flush: got %0d siwu pulses cnt=%0d want 0 2", siwu_lo.size(), o_cnt);
        end
    endtask

    task automatic test_random();
        int g = 0;
        do_reset(0);
        for (int i = 0; i < 6 * PKT; i++) begin q0.push_back(8'($urandom)); q1.push_back(8'($urandom)); end
        rdy_en = 2'b11; txe_rand = 1; val_rand = 1;
        while (ends < 6 && g < 3000) begin step(); g++; end
        checks++;
        if (ends < 6) begin errors++; $display("FAIL random progress: got %0d packets want 6", ends); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_underflow();
        test_reset_mid();
        test_no_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
